seq_multiplier_wb: RTL and testbench



---
 rtl/seq_mul_pkg.sv | 23 ++
 rtl/shift_add_datapath.sv | 64 ++++++
 rtl/seq_multiplier_wb.sv | 110 +++++++++++
 tb/tb_seq_multiplier_wb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared constants, state encoding and operand helper for the sequential
// shift-add multiplier that feeds the register-file write port.
package seq_mul_pkg;

  localparam int WIDTH      = 32;  // operand and result-word width
  localparam int REG_ADDR_W = 5;   // destination register number width
  localparam int CNT_W      = 6;   // iteration counter width, must hold WIDTH
  localparam int ITER_LAST  = 32;  // counter value reached on the final iteration

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } mulState_t;

  // Magnitude of a possibly-signed operand. The magnitude of the most negative
  // value wraps back to itself, which is the correct unsigned 32-bit magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                 input logic             signedMode);
    return (signedMode && value[WIDTH-1]) ? (~value + WIDTH'(1)) : value;
  endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Operand registers, 33-bit shift-add step and final sign correction.
// The product output is combinational and reflects the state after the
// iteration being performed on the current edge, so the controller can
// register the finished product on the same edge as the last iteration.
module shift_add_datapath
  import seq_mul_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             step,
  input  logic             signedMode,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] productLo,
  output logic [WIDTH-1:0] productHi
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     accHi;
  logic               neg;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     accHiNext;
  logic [WIDTH-1:0]   mplierNext;
  logic [2*WIDTH-1:0] rawProduct;
  logic [2*WIDTH-1:0] finalProduct;

  // One iteration: conditional add of the multiplicand, then shift the
  // accumulator/multiplier pair right by one as a single 65-bit value.
  always_comb begin
    sum          = accHi + (mplier[0] ? {1'b0, mcand} : '0);
    accHiNext    = {1'b0, sum[WIDTH:1]};
    mplierNext   = {sum[0], mplier[WIDTH-1:1]};
    rawProduct   = {accHiNext[WIDTH-1:0], mplierNext};
    finalProduct = neg ? (~rawProduct + 64'd1) : rawProduct;
    productLo    = finalProduct[WIDTH-1:0];
    productHi    = finalProduct[2*WIDTH-1:WIDTH];
  end

  // Operand capture on load, iteration on step.
  // NOTE: these are plain registers, not a memory array, so clearing them in
  // reset is cheap and keeps every downstream value X-free after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mcand  <= '0;
      mplier <= '0;
      accHi  <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= magnitude(opA, signedMode);
      mplier <= magnitude(opB, signedMode);
      accHi  <= '0;
      neg    <= signedMode & (opA[WIDTH-1] ^ opB[WIDTH-1]);
    end else if (step) begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, so ordering of these lines does not matter.
      accHi  <= accHiNext;
      mplier <= mplierNext;
    end
  end

endmodule

// File: rtl/seq_multiplier_wb.sv
// Sequential 32x32 multiplier placed between the register-file read ports and
// its write port. Accepts an operation in IDLE, iterates for 32 cycles, then
// presents the low word on the write port for one WB cycle (write enable only
// when the destination is not register 0). The high word is exposed too.
module seq_multiplier_wb
  import seq_mul_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Signed,
  input  logic [WIDTH-1:0]      BusA,
  input  logic [WIDTH-1:0]      BusB,
  input  logic [REG_ADDR_W-1:0] RdIn,
  output logic                  Busy,
  output logic                  Done,
  output logic [WIDTH-1:0]      BusW,
  output logic [REG_ADDR_W-1:0] RW,
  output logic                  RegWr,
  output logic [WIDTH-1:0]      ProductHi
);

  mulState_t        state;
  mulState_t        stateNext;
  logic [CNT_W-1:0] count;

  logic             loadOp;
  logic             stepOp;
  logic             lastIter;
  logic [WIDTH-1:0] productLo;
  logic [WIDTH-1:0] productHiNext;

  shift_add_datapath uDatapath (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (loadOp),
    .step       (stepOp),
    .signedMode (Signed),
    .opA        (BusA),
    .opB        (BusB),
    .productLo  (productLo),
    .productHi  (productHiNext)
  );

  // State register; reset aborts any in-flight operation without a write.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state: Start is only honoured in IDLE, so requests during RUN/WB drop.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (Start) stateNext = RUN;
      RUN:     if (lastIter) stateNext = WB;
      WB:      stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Control and status decode from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    loadOp   = 1'b0;
    stepOp   = 1'b0;
    lastIter = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    RegWr    = 1'b0;
    unique case (state)
      IDLE: loadOp = Start;
      RUN: begin
        Busy     = 1'b1;
        stepOp   = 1'b1;
        lastIter = (count == CNT_W'(ITER_LAST - 1));
      end
      WB: begin
        Busy  = 1'b1;
        Done  = 1'b1;
        RegWr = (RW != '0);
      end
      default: ;
    endcase
  end

  // Iteration counter, destination capture and write-port result registers.
  // The result words hold between WB cycles so ProductHi stays readable.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count     <= '0;
      RW        <= '0;
      BusW      <= '0;
      ProductHi <= '0;
    end else begin
      if (loadOp) begin
        count <= '0;
        RW    <= RdIn;
      end else if (stepOp) begin
        count <= count + CNT_W'(1);
      end
      if (lastIter) begin
        BusW      <= productLo;
        ProductHi <= productHiNext;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier_wb.sv
// Self-checking bench for seq_multiplier_wb: a transaction-level reference
// model compared every cycle, plus hand-computed literal results.
module tb_seq_multiplier_wb;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] BusA = '0;
  logic [31:0] BusB = '0;
  logic [4:0]  RdIn = '0;
  logic        Busy;
  logic        Done;
  logic [31:0] BusW;
  logic [4:0]  RW;
  logic        RegWr;
  logic [31:0] ProductHi;

  int tests = 0;
  int fails = 0;
  logic cmpOn = 1'b0;

  seq_multiplier_wb dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Signed    (Signed),
    .BusA      (BusA),
    .BusB      (BusB),
    .RdIn      (RdIn),
    .Busy      (Busy),
    .Done      (Done),
    .BusW      (BusW),
    .RW        (RW),
    .RegWr     (RegWr),
    .ProductHi (ProductHi)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product straight from 64-bit arithmetic.
  function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Transaction model: an accepted request occupies 33 cycles after its
  // Start edge, the last being the write-back cycle.
  logic        mActive = 1'b0;
  int          mAge = 0;
  logic [63:0] mProd = '0;
  logic [31:0] mBusW = '0;
  logic [31:0] mHi = '0;
  logic [4:0]  mRW = '0;

  always @(posedge Clk) begin
    if (Reset) begin
      mActive <= 1'b0;
      mAge    <= 0;
      mBusW   <= '0;
      mHi     <= '0;
      mRW     <= '0;
    end else if (mActive) begin
      mAge <= mAge + 1;
      if (mAge == 31) begin
        mBusW <= mProd[31:0];
        mHi   <= mProd[63:32];
      end
      if (mAge == 32) mActive <= 1'b0;
    end else if (Start) begin
      mActive <= 1'b1;
      mAge    <= 0;
      mProd   <= refMul(BusA, BusB, Signed);
      mRW     <= RdIn;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (cmpOn) begin
      check("Busy",      {63'b0, Busy},  {63'b0, mActive});
      check("Done",      {63'b0, Done},  {63'b0, mActive && mAge == 32});
      check("RegWr",     {63'b0, RegWr}, {63'b0, mActive && mAge == 32 && mRW != 0});
      check("BusW",      {32'b0, BusW},      {32'b0, mBusW});
      check("RW",        {59'b0, RW},        {59'b0, mRW});
      check("ProductHi", {32'b0, ProductHi}, {32'b0, mHi});
    end
  end

  task automatic tick;
    @(negedge Clk);
  endtask

  // Wait up to a bounded number of cycles for Done; returns cycles waited.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!Done && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic [4:0] rd,
                       input logic [31:0] expLo, input logic [31:0] expHi, input logic expWr);
    int cycles;
    Start = 1'b1; Signed = sgn; BusA = a; BusB = b; RdIn = rd;
    tick();
    Start = 1'b0;
    BusA = ~a; BusB = b ^ 32'h5A5A_5A5A; Signed = ~sgn; RdIn = ~rd;
    check({name, " busy"}, {63'b0, Busy}, 64'd1);
    waitDone(cycles);
    check({name, " latency"}, 64'(cycles), 64'd32);
    check({name, " lo"}, {32'b0, BusW}, {32'b0, expLo});
    check({name, " hi"}, {32'b0, ProductHi}, {32'b0, expHi});
    check({name, " rw"}, {59'b0, RW}, {59'b0, rd});
    check({name, " regwr"}, {63'b0, RegWr}, {63'b0, expWr});
    tick();
    check({name, " done drop"}, {62'b0, Done, RegWr}, 64'd0);
  endtask

  initial begin
    int cycles;
    repeat (3) tick();
    Reset = 1'b0;
    cmpOn = 1'b1;
    check("reset busy", {63'b0, Busy}, 64'd0);
    check("reset outs", {BusW, ProductHi}, 64'd0);
    tick();

    runOp("t1 7*6",      32'd7,          32'd6,          1'b0, 5'd3,  32'd42,         32'd0,          1'b1);
    runOp("t2 s -3*5",   32'hFFFF_FFFD,  32'd5,          1'b1, 5'd7,  32'hFFFF_FFF1,  32'hFFFF_FFFF,  1'b1);
    runOp("t2 u -3*5",   32'hFFFF_FFFD,  32'd5,          1'b0, 5'd8,  32'hFFFF_FFF1,  32'h0000_0004,  1'b1);
    runOp("t3 u max^2",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 5'd31, 32'h0000_0001,  32'hFFFF_FFFE,  1'b1);
    runOp("t3 s min^2",  32'h8000_0000,  32'h8000_0000,  1'b1, 5'd1,  32'h0000_0000,  32'h4000_0000,  1'b1);
    runOp("t4 rd0",      32'd9,          32'd9,          1'b0, 5'd0,  32'd81,         32'd0,          1'b0);
    runOp("zero neg",    32'h0000_0000,  32'hFFFF_FFF0,  1'b1, 5'd2,  32'd0,          32'd0,          1'b1);

    // Test 5: Start during RUN and WB ignored; Start in following IDLE accepted.
    Start = 1'b1; Signed = 1'b0; BusA = 32'd1000; BusB = 32'd3; RdIn = 5'd4;
    tick();
    Start = 1'b0;
    for (int n = 1; n <= 34; n++) begin
      tick();
      if (n == 4) begin
        Start = 1'b1; BusA = 32'd11; BusB = 32'd13; RdIn = 5'd9;
      end
      if (n == 5) Start = 1'b0;
      if (n == 32) begin
        check("t5 first lo", {32'b0, BusW}, 64'd3000);
        check("t5 first done", {62'b0, Done, RegWr}, 64'd3);
        Start = 1'b1; BusA = 32'd12; BusB = 32'd10; RdIn = 5'd5;
      end
      if (n == 34) begin
        Start = 1'b0;
        check("t5 second busy", {63'b0, Busy}, 64'd1);
      end
    end
    waitDone(cycles);
    check("t5 second latency", 64'(cycles), 64'd32);
    check("t5 second lo", {32'b0, BusW}, 64'd120);
    check("t5 second rw", {59'b0, RW}, 64'd5);
    tick();

    // Test 6: reset mid-RUN aborts with no write, then a fresh op completes.
    Start = 1'b1; Signed = 1'b0; BusA = 32'd100; BusB = 32'd200; RdIn = 5'd6;
    tick();
    Start = 1'b0;
    for (int n = 1; n <= 9; n++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("t6 abort busy", {63'b0, Busy}, 64'd0);
    check("t6 abort outs", {BusW, ProductHi}, 64'd0);
    check("t6 abort rw", {59'b0, RW}, 64'd0);
    cycles = 0;
    for (int n = 0; n < 40; n++) begin
      if (Done || RegWr) cycles++;
      tick();
    end
    check("t6 no pulse", 64'(cycles), 64'd0);
    runOp("t6 after", 32'd100, 32'd200, 1'b0, 5'd6, 32'd20000, 32'd0, 1'b1);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
